dlx_fetch_unit: RTL



---
 rtl/dlx_fetch_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/dlx_fetch_unit.sv
// DLX instruction-fetch stage: reads instruction memory at PC and holds the word in IR
// until decode accepts it, pulsing PC_EN once per delivered instruction.
module dlx_fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RUN,
  input  logic [ADDR_W-1:0] PC,
  output logic              PC_EN,
  output logic              IMEM_RD,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  input  logic [DATA_W-1:0] IMEM_RDATA,
  input  logic              IMEM_ACK,
  output logic [DATA_W-1:0] IR,
  output logic [ADDR_W-1:0] IR_PC,
  output logic              IR_VALID,
  input  logic              IR_READY,
  input  logic              FLUSH,
  output logic [15:0]       FETCH_CNT
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t              state, state_next;
  logic                pc_en, pc_en_next;
  logic                imem_rd, imem_rd_next;
  logic [ADDR_W-1:0]   imem_addr, imem_addr_next;
  logic [DATA_W-1:0]   ir, ir_next;
  logic [ADDR_W-1:0]   ir_pc, ir_pc_next;
  logic                ir_valid, ir_valid_next;
  logic [15:0]         fetch_cnt, fetch_cnt_next;
  logic                discard, discard_next;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      pc_en     <= 1'b0;
      imem_rd   <= 1'b0;
      imem_addr <= '0;
      ir        <= '0;
      ir_pc     <= '0;
      ir_valid  <= 1'b0;
      fetch_cnt <= '0;
      discard   <= 1'b0;
    end else begin
      state     <= state_next;
      pc_en     <= pc_en_next;
      imem_rd   <= imem_rd_next;
      imem_addr <= imem_addr_next;
      ir        <= ir_next;
      ir_pc     <= ir_pc_next;
      ir_valid  <= ir_valid_next;
      fetch_cnt <= fetch_cnt_next;
      discard   <= discard_next;
    end
  end

  always_comb begin
    state_next     = state;
    pc_en_next     = 1'b0;
    imem_rd_next   = imem_rd;
    imem_addr_next = imem_addr;
    ir_next        = ir;
    ir_pc_next     = ir_pc;
    ir_valid_next  = ir_valid;
    fetch_cnt_next = fetch_cnt;
    discard_next   = discard;

    case (state)
      IDLE: begin
        if (RUN) state_next = REQ;
      end
      REQ: begin
        imem_addr_next = PC;
        imem_rd_next   = 1'b1;
        state_next     = WAIT;
      end
      WAIT: begin
        if (IMEM_ACK) begin
          imem_rd_next = 1'b0;
          if (discard) begin
            discard_next = 1'b0;
            state_next   = IDLE;
          end else begin
            ir_next        = IMEM_RDATA;
            ir_pc_next     = imem_addr;
            ir_valid_next  = 1'b1;
            pc_en_next     = 1'b1;
            fetch_cnt_next = fetch_cnt + 16'd1;
            state_next     = HOLD;
          end
        end
      end
      HOLD: begin
        if (IR_READY) begin
          ir_valid_next = 1'b0;
          state_next    = RUN ? REQ : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A bus read cannot be aborted, so a flush during WAIT only marks the
    // outstanding word to be dropped when it eventually returns.
    if (FLUSH) begin
      ir_valid_next  = 1'b0;
      pc_en_next     = 1'b0;
      ir_next        = ir;
      ir_pc_next     = ir_pc;
      fetch_cnt_next = fetch_cnt;
      if (state == WAIT && !IMEM_ACK) begin
        discard_next = 1'b1;
      end else begin
        imem_rd_next   = 1'b0;
        imem_addr_next = imem_addr;
        discard_next   = 1'b0;
        state_next     = IDLE;
      end
    end
  end

  assign PC_EN     = pc_en;
  assign IMEM_RD   = imem_rd;
  assign IMEM_ADDR = imem_addr;
  assign IR        = ir;
  assign IR_PC     = ir_pc;
  assign IR_VALID  = ir_valid;
  assign FETCH_CNT = fetch_cnt;

endmodule
